// File: rtl/seq_detector_if.sv
// seq_detector_if: serial input qualifiers and detection results for seq_detector
interface seq_detector_if #(parameter int CNT_W = 8);
  logic din_valid;
  logic din;
  logic clear;
  logic match;
  logic [CNT_W-1:0] match_count;
  logic saturated;
  logic fill_ready;
  modport master(output din_valid, din, clear, input match, match_count, saturated, fill_ready);
  modport slave(input din_valid, din, clear, output match, match_count, saturated, fill_ready);
endinterface

// File: rtl/seq_detector.sv
// seq_detector: overlapping serial pattern detector with saturating match counter
module seq_detector #(
  parameter int PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN = 4'b1011,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  seq_detector_if.slave bus
);
  localparam int FW = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_W);
  logic [PATTERN_W-1:0] history, hist_nx;
  logic [FW-1:0] fill, fill_nx;
  logic [CNT_W-1:0] cnt;
  logic hit, match, sat, fill_ready;
  // Candidate shift/fill for a valid bit; the fill guard keeps the zeroed history from matching early
  always_comb begin
    hist_nx = {history[PATTERN_W-2:0], bus.din};
    fill_nx = fill == FULL ? fill : fill + 1'b1;
    hit = bus.din_valid && hist_nx == PATTERN && fill_nx == FULL;
  end
  // State update: clear outranks sampling, gaps hold history and fill untouched
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      history <= '0;
      fill <= '0;
      fill_ready <= 1'b0;
      match <= 1'b0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (bus.clear) begin
      history <= '0;
      fill <= '0;
      fill_ready <= 1'b0;
      match <= 1'b0;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      match <= hit;
      if (bus.din_valid) begin
        history <= hist_nx;
        fill <= fill_nx;
        fill_ready <= fill_nx == FULL;
      end
      if (hit) begin
        cnt <= &cnt ? cnt : cnt + 1'b1;
        sat <= sat | &cnt;
      end
    end
  assign bus.match = match;
  assign bus.match_count = cnt;
  assign bus.saturated = sat;
  assign bus.fill_ready = fill_ready;
endmodule
